uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge.sv | 121 ++++++++++++
 tb/tb_uart_bus_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART-to-bus command bridge: 'W' AH AL DH DL writes, 'R' AH AL reads a 16-bit bus word.
// Replies go back through the UART (ACK/NAK for writes, DH DL/NAK for reads, BAD for unknown commands).
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  NAK_CODE = 8'h15,
    parameter logic [7:0]  BAD_CODE = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        active,
    output logic [7:0]  err_count
);

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] ACK_CODE = 8'h06;

    typedef enum logic [2:0] {
        IDLE, GET_AH, GET_AL, GET_DH, GET_DL, BUS, SEND, SEND_GAP
    } state_t;

    state_t      state, state_nx;
    logic        rd_q;
    logic [15:0] tmo_cnt;
    logic [15:0] reply;
    logic [1:0]  reply_left;
    logic        take;
    logic        timeout_hit;
    logic        bad_cmd;

    always_comb begin
        // rd_q blocks a capture in the cycle right after a strobe, while the UART is still clearing rx_valid
        take        = rx_valid && !rd_q && !reset &&
                      (state inside {IDLE, GET_AH, GET_AL, GET_DH, GET_DL});
        rx_rd       = take;
        tx_wr       = (state == SEND) && !tx_busy;
        tx_data     = reply[15:8];
        bus_req     = (state == BUS);
        active      = (state != IDLE);
        timeout_hit = (state == BUS) && !bus_ack && (tmo_cnt == 16'(TIMEOUT - 1));
        bad_cmd     = take && (state == IDLE) && (rx_data != CMD_W) && (rx_data != CMD_R);
        state_nx    = state;
        case (state)
            IDLE:     if (take) state_nx = bad_cmd ? SEND : GET_AH;
            GET_AH:   if (take) state_nx = GET_AL;
            GET_AL:   if (take) state_nx = bus_we ? GET_DH : BUS;
            GET_DH:   if (take) state_nx = GET_DL;
            GET_DL:   if (take) state_nx = BUS;
            BUS:      if (bus_ack || timeout_hit) state_nx = SEND;
            SEND:     if (tx_wr) state_nx = SEND_GAP;
            SEND_GAP: state_nx = (reply_left == 2'd0) ? IDLE : SEND;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_q       <= 1'b0;
            tmo_cnt    <= '0;
            reply      <= '0;
            reply_left <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            err_count  <= '0;
        end else begin
            state <= state_nx;
            rd_q  <= take;
            tmo_cnt <= (state == BUS) ? tmo_cnt + 16'd1 : '0;

            if (take) begin
                case (state)
                    IDLE: begin
                        bus_we <= (rx_data == CMD_W);
                        if (bad_cmd) begin
                            reply      <= {BAD_CODE, 8'h00};
                            reply_left <= 2'd1;
                        end
                    end
                    GET_AH:  bus_addr[15:8]  <= rx_data;
                    GET_AL:  bus_addr[7:0]   <= rx_data;
                    GET_DH:  bus_wdata[15:8] <= rx_data;
                    GET_DL:  bus_wdata[7:0]  <= rx_data;
                    default: ;
                endcase
            end

            if (state == BUS) begin
                if (bus_ack) begin
                    reply      <= bus_we ? {ACK_CODE, 8'h00} : bus_rdata;
                    reply_left <= bus_we ? 2'd1 : 2'd2;
                end else if (timeout_hit) begin
                    reply      <= {NAK_CODE, 8'h00};
                    reply_left <= 2'd1;
                end
            end

            if (tx_wr) begin
                reply      <= {reply[7:0], 8'h00};
                reply_left <= reply_left - 2'd1;
            end

            if ((bad_cmd || timeout_hit) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed protocol cases plus randomized transactions
// compared against a transaction-level reference model of the command protocol.
module tb_uart_bus_bridge;

    localparam int unsigned TMO = 20;
    localparam logic [7:0]  NAK = 8'h15;
    localparam logic [7:0]  BAD = 8'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        tx_busy;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic        active;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    uart_bus_bridge #(.TIMEOUT(TMO), .NAK_CODE(NAK), .BAD_CODE(BAD)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .active(active), .err_count(err_count)
    );

    int          total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ack_delay = -1;
    logic [15:0] ack_data = '0;
    bit          spurious = 1'b0;
    int          req_cycles = 0;
    int          ack_cyc = -1;
    int          first_wr_cyc = -1;
    int          bus_cnt = 0;
    logic [32:0] bus_first;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;
    logic [7:0]  txq[$];
    logic [32:0] busq[$];
    logic [7:0]  host_q[$];
    int          err_model = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // bus slave: acks after ack_delay request cycles, optional stray acks while idle
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req === 1'b1) begin
                if (bus_cnt == 0) begin
                    bus_first = {bus_we, bus_addr, bus_wdata};
                    busq.push_back(bus_first);
                end else begin
                    chk("bus_stable", {bus_we, bus_addr, bus_wdata}, bus_first);
                end
                req_cycles++;
                if (bus_cnt == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = ack_data;
                    ack_cyc   = cyc;
                end
                bus_cnt++;
            end else begin
                bus_cnt = 0;
                if (spurious && $urandom_range(5) == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = 16'hDEAD;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (tx_wr === 1'b1) begin
            chk("tx_wr_busy", tx_busy, 0);
            chk("tx_wr_gap", prev_wr, 0);
            txq.push_back(tx_data);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (rx_rd === 1'b1) chk("rx_rd_gap", prev_rd, 0);
        prev_wr = tx_wr;
        prev_rd = rx_rd;
    end

    // UART transmitter: busy rises one cycle after tx_wr and lasts a random time
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_wr === 1'b1) begin
                @(posedge clk);
                #1;
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    task automatic host_send();
        int k;
        @(posedge clk);
        #1;
        while (host_q.size() > 0) begin
            rx_data  = host_q.pop_front();
            rx_valid = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (rx_rd !== 1'b1 && k < 500);
            if (rx_rd !== 1'b1) chk("rx_rd_wait", rx_rd, 1);
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            if ($urandom_range(2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (active !== 1'b0 && k < 3000);
        chk("idle_wait", active, 0);
    endtask

    // kind: 0 = write, 1 = read, 2 = unknown command (byte taken from data[7:0])
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [15:0] data,
                           input int delay, input logic [15:0] rdata);
        logic [7:0] exp_q[$];
        logic [7:0] cmd;
        bit         ok;
        int         exp_req;
        ack_delay    = delay;
        ack_data     = rdata;
        txq.delete();
        busq.delete();
        req_cycles   = 0;
        first_wr_cyc = -1;
        ack_cyc      = -1;
        cmd = (kind == 0) ? 8'h57 : (kind == 1) ? 8'h52 : data[7:0];
        host_q.push_back(cmd);
        if (kind < 2) begin
            host_q.push_back(addr[15:8]);
            host_q.push_back(addr[7:0]);
        end
        if (kind == 0) begin
            host_q.push_back(data[15:8]);
            host_q.push_back(data[7:0]);
        end
        host_send();
        wait_idle();

        ok = (kind < 2) && (delay >= 0) && (delay < int'(TMO));
        if (kind == 2)      exp_q.push_back(BAD);
        else if (!ok)       exp_q.push_back(NAK);
        else if (kind == 0) exp_q.push_back(8'h06);
        else begin
            exp_q.push_back(rdata[15:8]);
            exp_q.push_back(rdata[7:0]);
        end
        if (kind == 2 || !ok) err_model = (err_model >= 255) ? 255 : err_model + 1;
        exp_req = (kind == 2) ? 0 : ok ? delay + 1 : int'(TMO);

        chk("reply_len", txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < txq.size()) chk("reply_byte", txq[i], exp_q[i]);
        chk("req_cycles", req_cycles, exp_req);
        chk("bus_count", busq.size(), (kind < 2) ? 1 : 0);
        if (kind < 2 && busq.size() > 0) begin
            chk("bus_we", busq[0][32], (kind == 0) ? 1 : 0);
            chk("bus_addr", busq[0][31:16], addr);
            if (kind == 0) chk("bus_wdata", busq[0][15:0], data);
        end
        if (ok && kind == 1) chk("rd_latency_min", (first_wr_cyc - ack_cyc) >= 1, 1);
        chk("err_count", err_count, err_model);
    endtask

    initial begin
        int k;
        int kind;
        int r;
        int delay;
        logic [15:0] d;

        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h57;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_rd", rx_rd, 0);
        chk("reset_outs", {rx_rd, tx_wr, tx_data, bus_req, bus_we, bus_addr, bus_wdata, active, err_count}, '0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        run_txn(0, 16'h1234, 16'hABCD, 3, 16'h0000);

        repeat (10) @(posedge clk);
        run_txn(1, 16'h0010, 16'h0000, 2, 16'hBEEF);
        chk("rd_latency", first_wr_cyc - ack_cyc, 1);

        run_txn(1, 16'h0020, 16'h0000, -1, 16'h0000);
        chk("timeout_err1", err_count, 1);

        run_txn(2, 16'h0000, 16'h0041, -1, 16'h0000);

        run_txn(1, 16'h0030, 16'h0000, int'(TMO) - 1, 16'hCAFE);

        spurious = 1'b1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(2);
            r = $urandom_range(9);
            delay = (r == 0) ? -1 : (r == 1) ? int'(TMO) - 1 : int'($urandom_range(TMO + 3));
            d = 16'($urandom);
            if (kind == 2)
                while (d[7:0] == 8'h57 || d[7:0] == 8'h52) d[7:0] = 8'($urandom);
            run_txn(kind, 16'($urandom), d, delay, 16'($urandom));
        end
        spurious = 1'b0;

        while (err_model < 255) run_txn(2, 16'h0000, 16'h0041, -1, 16'h0000);
        run_txn(2, 16'h0000, 16'h00A5, -1, 16'h0000);
        chk("err_saturate", err_count, 8'hFF);

        ack_delay = -1;
        host_q.push_back(8'h57);
        host_q.push_back(8'h12);
        host_q.push_back(8'h34);
        host_q.push_back(8'hAB);
        host_q.push_back(8'hCD);
        host_send();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus_req !== 1'b1 && k < 100);
        chk("rst_req_seen", bus_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", {bus_req, tx_wr, rx_rd, active, bus_we, bus_addr, bus_wdata, tx_data, err_count}, '0);
        err_model = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        txq.delete();
        repeat (30) @(negedge clk);
        chk("rst_no_tx", txq.size(), 0);
        chk("rst_idle", active, 0);
        run_txn(1, 16'h0010, 16'h0000, 2, 16'h1357);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

endmodule
